// File: rtl/hack_alu_pkg.sv
// hack_alu_pkg: Hack ALU control encodings {zx,nx,zy,ny,f,no} and the MUL sequencer state type.
package hack_alu_pkg;
    localparam logic [5:0] ALU_CONST0 = 6'b101010;
    localparam logic [5:0] ALU_CONST1 = 6'b111111;
    localparam logic [5:0] ALU_NEG1   = 6'b111010;
    localparam logic [5:0] ALU_X      = 6'b001100;
    localparam logic [5:0] ALU_Y      = 6'b110000;
    localparam logic [5:0] ALU_NOT_X  = 6'b001101;
    localparam logic [5:0] ALU_NOT_Y  = 6'b110001;
    localparam logic [5:0] ALU_NEG_X  = 6'b001111;
    localparam logic [5:0] ALU_NEG_Y  = 6'b110011;
    localparam logic [5:0] ALU_X_INC  = 6'b011111;
    localparam logic [5:0] ALU_Y_INC  = 6'b110111;
    localparam logic [5:0] ALU_X_DEC  = 6'b001110;
    localparam logic [5:0] ALU_Y_DEC  = 6'b110010;
    localparam logic [5:0] ALU_ADD    = 6'b000010;
    localparam logic [5:0] ALU_X_SUB  = 6'b010011;
    localparam logic [5:0] ALU_Y_SUB  = 6'b000111;
    localparam logic [5:0] ALU_AND    = 6'b000000;
    localparam logic [5:0] ALU_OR     = 6'b010101;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} mul_state_e;
endpackage

// File: rtl/alu_mul_datapath.sv
// alu_mul_datapath: shift-and-add registers for the MUL sequencer; the add itself is done by the external ALU.
module alu_mul_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] alu_out_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mc_o,
    output logic [WIDTH-1:0] acc_next_o,
    output logic             ovf_next_o,
    output logic             last_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mp_q, mp_d, mp_sh;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, carry;

    always_comb begin
        mp_sh = mp_q >> 1;
        // carry out of acc + mc, recovered from the operand and sum MSBs
        carry = (acc_q[WIDTH-1] & mc_q[WIDTH-1])
              | ((acc_q[WIDTH-1] | mc_q[WIDTH-1]) & ~alu_out_i[WIDTH-1]);
        acc_d = load_i ? '0 : (step_i && mp_q[0]) ? alu_out_i : acc_q;
        mc_d  = load_i ? a_i : step_i ? mc_q << 1 : mc_q;
        mp_d  = load_i ? b_i : step_i ? mp_sh : mp_q;
        cnt_d = load_i ? '0 : step_i ? cnt_q + CW'(1) : cnt_q;
        // a set bit leaving mc while multiplier bits remain would land above WIDTH
        ovf_d = load_i ? 1'b0
              : step_i ? ovf_q | (mp_q[0] & carry) | (mc_q[WIDTH-1] & (|mp_sh))
              : ovf_q;
        last_o = (mp_sh == '0) || (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            mp_q  <= mp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o      = acc_q;
    assign mc_o       = mc_q;
    assign acc_next_o = acc_d;
    assign ovf_next_o = ovf_d;
endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned multiply that time-shares the Hack ALU as its adder.
module alu_mul_sequencer
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng
);
    mul_state_e       state_q, state_d;
    logic             step, load, last, ovf_next, overflow_q, unused_flags;
    logic [WIDTH-1:0] acc, mc, acc_next, product_q;

    assign step = state_q == S_STEP;
    assign load = state_q == S_IDLE && start;
    assign unused_flags = alu_zr ^ alu_ng;

    always_comb begin
        state_d = state_q == S_IDLE ? (start ? S_STEP : S_IDLE)
                : step ? (last ? S_DONE : S_STEP)
                : S_IDLE;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = step ? ALU_ADD : ALU_CONST0;
        alu_x = step ? acc : '0;
        alu_y = step ? mc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (step && last) begin
                product_q  <= acc_next;
                overflow_q <= ovf_next;
            end
        end
    end

    alu_mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a),
        .b_i       (b),
        .alu_out_i (alu_out),
        .acc_o     (acc),
        .mc_o      (mc),
        .acc_next_o(acc_next),
        .ovf_next_o(ovf_next),
        .last_o    (last)
    );

    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign product  = product_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vectors with a cycle-level reference model of the multiply sequencer.
module tb_alu_mul_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, overflow;
    logic [15:0] product, alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    int          vectors = 0, miscompares = 0;
    bit          check_en = 1'b0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product), .overflow(overflow),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    // Hack ALU standing in for the real datapath ALU
    always_comb begin
        logic [15:0] xv, yv, ov;
        xv = alu_zx ? 16'h0 : alu_x;
        xv = alu_nx ? ~xv : xv;
        yv = alu_zy ? 16'h0 : alu_y;
        yv = alu_ny ? ~yv : yv;
        ov = alu_f ? xv + yv : xv & yv;
        ov = alu_no ? ~ov : ov;
        alu_out = ov;
        alu_zr = ov == 16'h0;
        alu_ng = ov[15];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nsteps(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) if (v[i]) return i + 1;
        return 1;
    endfunction

    // Model: rem counts cycles left in the operation (STEP cycles + the DONE cycle)
    int          rem = 0, mn = 0;
    logic [15:0] ma = '0, mb = '0, m_prod = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] full;
        if (!rst_n) begin
            rem = 0; m_prod = '0; m_ovf = 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                ma = a; mb = b; mn = nsteps(b); rem = mn + 1;
            end
        end else begin
            if (rem == 2) begin
                full = {16'h0, ma} * {16'h0, mb};
                m_prod = full[15:0];
                m_ovf = |full[31:16];
            end
            rem--;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int          k;
            logic [31:0] mask, px, py;
            logic        stp;
            stp  = rem > 1;
            k    = mn + 1 - rem;
            mask = (32'd1 << k) - 32'd1;
            px   = {16'h0, ma} * {16'h0, mb & mask[15:0]};
            py   = {16'h0, ma} << k;
            chk("busy", {31'd0, busy}, {31'd0, rem > 0});
            chk("done", {31'd0, done}, {31'd0, rem == 1});
            chk("product", {16'd0, product}, {16'd0, m_prod});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("alu_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                stp ? 32'b000010 : 32'b101010);
            chk("alu_x", {16'd0, alu_x}, stp ? {16'd0, px[15:0]} : 32'd0);
            chk("alu_y", {16'd0, alu_y}, stp ? {16'd0, py[15:0]} : 32'd0);
        end
    end

    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] ep,
                       input logic eo, input int elat, input int extra);
        int  cyc;
        bit  got;
        @(posedge clk); #2;
        start = 1'b1; a = ta; b = tb_;
        @(posedge clk); #2;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (cyc == extra - 1) begin start = 1'b1; a = 16'h0003; b = 16'h0003; end
            else if (cyc == extra) start = 1'b0;
        end
        start = 1'b0;
        chk("latency", cyc, elat);
        chk("result", {16'd0, product}, {16'd0, ep});
        chk("result_ovf", {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        int ndone;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'b101010);
        @(posedge clk); #2;
        rst_n = 1'b1; check_en = 1'b1;

        run(16'h0005, 16'h0003, 16'h000F, 1'b0, 3, -1);
        run(16'h0011, 16'h0000, 16'h0000, 1'b0, 2, -1);
        run(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 2, -1);
        run(16'h0100, 16'h0100, 16'h0000, 1'b1, 10, -1);
        run(16'h8000, 16'h0002, 16'h0000, 1'b1, 3, -1);
        run(16'h00FF, 16'h8001, 16'h80FF, 1'b1, 17, 5);

        // reset in cycle 3 of an 8-step operation
        @(posedge clk); #2;
        start = 1'b1; a = 16'h1234; b = 16'h00FF;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_product", {16'd0, product}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run(16'h0002, 16'h0003, 16'h0006, 1'b0, 3, -1);

        // start held high: 4-cycle cadence (IDLE accept, 2 STEP, DONE)
        @(posedge clk); #2;
        start = 1'b1; a = 16'h0005; b = 16'h0003;
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        chk("b2b_done_count", ndone, 4);
        repeat (8) @(negedge clk);
        chk("b2b_product", {16'd0, product}, 32'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle unsigned multiplier controller that time-shares the existing combinational Hack ALU (x, y, zx, nx, zy, ny, f, no -> d_out, zr, ng) to perform shift-and-add multiplication. It accepts start/operands from a requester, drives the ALU operand and control pins each cycle, and returns a registered 16-bit product with an overflow flag. It sits beside the ALU in the CPU datapath as the sequencer for a MUL extension.

Parameters:
WIDTH, 16, operand/product width; must match the ALU data width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request pulse; sampled only in IDLE.
a  in  WIDTH  multiplicand, latched on accepted start.
b  in  WIDTH  multiplier, latched on accepted start.
busy  out  1  high from the cycle after accepted start until done.
done  out  1  one-cycle pulse; product/overflow valid from this cycle.
product  out  WIDTH  low WIDTH bits of a*b, registered, held until next accepted start.
overflow  out  1  high if the true 2*WIDTH product has any nonzero upper bit.
alu_x  out  WIDTH  ALU x operand.
alu_y  out  WIDTH  ALU y operand.
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
alu_out  in  WIDTH  ALU d_out, combinational, same cycle.
alu_zr  in  1  ALU zr (unused for arithmetic; kept for symmetry).
alu_ng  in  1  ALU ng (unused).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, product=0, overflow=0, alu_x=0, alu_y=0, ALU controls = CONST0 (zx=1 nx=0 zy=1 ny=0 f=1 no=0).
- States: IDLE, STEP, DONE.
- IDLE: ALU driven with CONST0. On start=1: acc<=0, mc<=a, mp<=b, ovf<=0, cnt<=0, -> STEP.
- STEP (one multiplier bit per cycle): alu_x=acc, alu_y=mc, controls=ADD (zx=0 nx=0 zy=0 ny=0 f=1 no=0).
  - If mp[0]=1: acc<=alu_out; carry = (acc[W-1]&mc[W-1]) | ((acc[W-1]|mc[W-1]) & ~alu_out[W-1]); carry sets ovf.
  - If mp[0]=0: acc holds.
  - Always: mc<=mc<<1, mp<=mp>>1, cnt<=cnt+1. If mc[W-1]=1 and (mp>>1)!=0, set ovf.
  - Exit to DONE when (mp>>1)==0 or cnt==WIDTH-1; else stay.
- STEP cycle count = max(1, msb_index(b)+1); b=0 takes exactly 1 STEP cycle.
- DONE: product<=final acc, overflow<=final ovf, done=1 for exactly this cycle (product/overflow outputs updated on entry edge so they are valid while done=1), -> IDLE. ALU driven with CONST0.
- busy=1 in STEP and DONE; 0 in IDLE.
- Latency: start sampled at edge 0; done high in cycle n+1 where n = STEP cycles.
- start while busy: ignored, no queuing. start asserted in the DONE cycle: ignored; accepted next IDLE cycle.
- ovf is sticky within one operation, cleared only by accepted start or reset.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH; mc and acc WIDTH bits; cnt is clog2(WIDTH)+1 bits.

Decomposition:
- Shared package hack_alu_pkg: 6-bit ALU control encodings (ALU_CONST0=101010, ALU_ADD=000010, plus the remaining Hack comp codes for reuse by the CPU decoder) and the state enum.
- Natural sub-module: alu_mul_datapath (acc/mc/mp/cnt registers, shift, carry/overflow logic); FSM stays in top. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- a=0x0005, b=0x0003 start -> busy next cycle, 2 STEP cycles, done at cycle 3, product=0x000F, overflow=0.
- a=0x0011, b=0x0000 -> 1 STEP cycle, done at cycle 2, product=0x0000, overflow=0; ALU controls=ADD only during STEP, CONST0 otherwise.
- a=0xFFFF, b=0x0001 -> product=0xFFFF, overflow=0; a=0x0100, b=0x0100 -> product=0x0000, overflow=1; a=0x8000, b=0x0002 -> product=0x0000, overflow=1 (shift-out path).
- a=0x00FF, b=0x8001 -> 16 STEP cycles, done at cycle 17, product=0x80FF, overflow=1; second start pulse at cycle 5 ignored (single done, same result).
- Reset asserted in cycle 3 of a=0x1234, b=0x00FF -> outputs at reset values immediately, no done; next a=0x0002, b=0x0003 -> product=0x0006.
- Back-to-back: start held high continuously -> operations separated by one IDLE cycle after each DONE; product held stable between done pulses.
